bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter N_BITS, default 14, is the binary input width; legal range 1..16, so 5 BCD digits always suffice.
REQ-002 sysclk  input  1  system clock; all state is updated on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  conversion request, sampled at the rising edge of sysclk.
REQ-005 bin_in  input  N_BITS  unsigned binary value to convert (frequency display word).
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking that new BCD outputs are valid.
REQ-008 BCD_0  output  4  units digit.
REQ-009 BCD_1  output  4  tens digit.
REQ-010 BCD_2  output  4  hundreds digit.
REQ-011 BCD_3  output  4  thousands digit.
REQ-012 BCD_4  output  4  ten-thousands digit.

Function
REQ-013 The block SHALL implement the sequential double-dabble (shift-add-3) algorithm, one bit per clock.
REQ-014 The FSM SHALL have two states, IDLE and SHIFT.
REQ-015 In IDLE, start=1 SHALL capture bin_in into a shift register, clear a 20-bit scratch register, set the bit counter to N_BITS, set busy=1, and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL first add 3 to every scratch digit that is >=5, then shift {scratch, shift register} left by one bit, then decrement the counter.
REQ-017 After the N_BITS-th shift the FSM SHALL return to IDLE; on that transition edge BCD_0..BCD_4 SHALL load from the scratch register, done SHALL be 1 for exactly one cycle, and busy SHALL become 0.
REQ-018 Latency: with start sampled at edge k, the outputs update and done=1 at edge k+N_BITS+1; busy is 1 from edge k to edge k+N_BITS+1.
REQ-019 BCD outputs SHALL hold their last converted value between conversions and SHALL never show partial results.
REQ-020 start SHALL be ignored while busy=1; bin_in changes during a conversion SHALL NOT affect the result.
REQ-021 A start asserted in the cycle where done=1 SHALL be accepted (state is IDLE), which gives back-to-back conversions every N_BITS+1 cycles.
REQ-022 Every output digit SHALL be in the range 0..9; no add-3 carry SHALL be lost for any input up to 2^N_BITS-1.
REQ-023 done and busy SHALL be registered outputs with no combinational path from start.

Reset
REQ-024 Asserting reset SHALL immediately force the FSM to IDLE, set busy=0, done=0, clear the counter, the shift register and scratch, and set BCD_0..BCD_4 to 0.
REQ-025 A reset during SHIFT SHALL abort the conversion with no done pulse; the first start after reset is released SHALL be handled normally.

Verification
REQ-026 bin_in=0, start pulse -> done at edge k+15; all digits 0.
REQ-027 bin_in=16383 -> BCD_4..BCD_0 = 1,6,3,8,3; done is high for exactly one cycle.
REQ-028 bin_in=9999, then start again in the done cycle with bin_in=10000 -> 0,9,9,9,9, then 1,0,0,0,0 exactly 15 cycles later.
REQ-029 start held high and bin_in changed to 123 mid-conversion of 4096 -> result 0,4,0,9,6; no extra conversion starts while busy.
REQ-030 reset asserted 7 cycles into a conversion of 5555 -> outputs 0, busy=0, no done pulse; a following start with 42 -> 0,0,0,4,2.
REQ-031 Randomized check: 1000 random 14-bit values compared against a decimal reference model, with latency checked on every conversion.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int N_BITS = 14
);
    logic              start;
    logic [N_BITS-1:0] bin_in;
    logic              busy;
    logic              done;
    logic [3:0]        BCD_0;
    logic [3:0]        BCD_1;
    logic [3:0]        BCD_2;
    logic [3:0]        BCD_3;
    logic [3:0]        BCD_4;

    modport master (
        output start, bin_in,
        input  busy, done, BCD_0, BCD_1, BCD_2, BCD_3, BCD_4
    );

    modport slave (
        input  start, bin_in,
        output busy, done, BCD_0, BCD_1, BCD_2, BCD_3, BCD_4
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, results
// published only when the full conversion is complete.
module bin2bcd_seq #(
    parameter int N_BITS = 14
) (
    input  logic          sysclk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] sr_q, sr_d;
    logic [19:0]       scr_q, scr_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [19:0]       bcd_q, bcd_d;
    logic [15:0]       adj;

    // The top digit is below 5 before every shift for inputs up to
    // 16 bits, so its add-3 is an identity and it passes straight through.
    always_comb begin
        adj = '0;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = scr_q[4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = bus.bin_in;
                    scr_d   = '0;
                    cnt_d   = 5'(N_BITS);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != 5'd0) begin
                    scr_d = {scr_q[18:16], adj, sr_q[N_BITS-1]};
                    sr_d  = sr_q << 1;
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    bcd_d   = scr_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.BCD_0 = bcd_q[3:0];
    assign bus.BCD_1 = bcd_q[7:4];
    assign bus.BCD_2 = bcd_q[11:8];
    assign bus.BCD_3 = bcd_q[15:12];
    assign bus.BCD_4 = bcd_q[19:16];
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench: stimulus pushes expected digits and due cycle,
// a negedge monitor pops and checks on every done pulse.
module tb_bin2bcd_seq;
    localparam int N = 14;

    typedef struct {
        logic [19:0] bcd;
        int          due;
    } exp_t;

    logic sysclk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [19:0] last_bcd = '0;

    bin2bcd_seq_if #(.N_BITS(N)) bus ();

    bin2bcd_seq #(.N_BITS(N)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic logic [19:0] model(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [19:0] digits();
        return {bus.BCD_4, bus.BCD_3, bus.BCD_2, bus.BCD_1, bus.BCD_0};
    endfunction

    // Monitor
    always @(negedge sysclk) begin
        exp_t e;
        if (!reset) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("bcd", 32'(digits()), 32'(e.bcd));
                    check("latency", 32'(cyc), 32'(e.due));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                    last_bcd = e.bcd;
                end
            end else begin
                check("hold", 32'(digits()), 32'(last_bcd));
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge sysclk);
        while (bus.busy && t < 100) begin
            @(negedge sysclk);
            t++;
        end
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [N-1:0] v, input logic [19:0] e);
        wait_idle();
        bus.bin_in = v;
        bus.start  = 1'b1;
        sb.push_back('{bcd: e, due: cyc + N + 2});
        @(negedge sysclk);
        bus.start = 1'b0;
        check("busy_set", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        int t;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge sysclk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(digits()), 32'd0);
        reset = 1'b0;

        issue(14'd0, 20'h00000);
        issue(14'd16383, 20'h16383);

        // Back-to-back: second start lands in the done cycle
        issue(14'd9999, 20'h09999);
        t = 0;
        while (!bus.done && t < 40) begin
            @(negedge sysclk);
            t++;
        end
        check("b2b_done_seen", 32'(bus.done), 32'd1);
        bus.bin_in = 14'd10000;
        bus.start  = 1'b1;
        sb.push_back('{bcd: 20'h10000, due: cyc + N + 2});
        @(negedge sysclk);
        bus.start = 1'b0;

        // Held start, bin_in changed mid-conversion
        wait_idle();
        bus.bin_in = 14'd4096;
        bus.start  = 1'b1;
        sb.push_back('{bcd: 20'h04096, due: cyc + N + 2});
        repeat (3) @(negedge sysclk);
        bus.bin_in = 14'd123;
        repeat (5) @(negedge sysclk);
        bus.start = 1'b0;
        wait_idle();
        repeat (20) @(negedge sysclk);

        // Reset 7 cycles into a conversion
        bus.bin_in = 14'd5555;
        bus.start  = 1'b1;
        @(negedge sysclk);
        bus.start = 1'b0;
        repeat (6) @(negedge sysclk);
        reset = 1'b1;
        sb.delete();
        last_bcd = '0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd", 32'(digits()), 32'd0);
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        repeat (20) @(negedge sysclk);
        issue(14'd42, 20'h00042);

        // Reference-model sweep
        for (int i = 0; i < 1000; i++) begin
            int v;
            v = int'($urandom_range(0, 16383));
            issue(14'(v), model(v));
        end

        wait_idle();
        repeat (3) @(negedge sysclk);
        check("drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
